// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// A grant lasts one packet or MAX_BURST beats, whichever ends first.
module sync_fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [N_REQ-1:0]                     req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]          req_data_i,
    input  logic [N_REQ-1:0]                     req_last_i,
    output logic [N_REQ-1:0]                     req_ready_o,
    input  logic                                 fifo_full_i,
    output logic                                 fifo_write_o,
    output logic [DATA_WIDTH-1:0]                fifo_data_o,
    output logic [N_REQ-1:0]                     grant_o,
    output logic [$clog2(MAX_BURST+1)-1:0]       beat_cnt_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [BW-1:0]    beat_q, beat_d;

    logic [PW:0]      arb_sum;
    logic [PW-1:0]    arb_idx;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic             xfer;
    logic             rel;
    logic [BW-1:0]    beat_inc;

    // Search downward so the last hit is the nearest index after ptr_q.
    always_comb begin
        arb_sum   = '0;
        arb_idx   = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            arb_sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (arb_sum >= (PW+1)'(N_REQ)) begin
                arb_sum = arb_sum - (PW+1)'(N_REQ);
            end
            arb_idx = arb_sum[PW-1:0];
            if (req_valid_i[arb_idx]) begin
                win_idx   = arb_idx;
                win_found = 1'b1;
            end
        end
    end

    // In GRANT the pointer always holds the owner index.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        beat_d       = beat_q;
        req_ready_o  = '0;
        fifo_write_o = 1'b0;
        fifo_data_o  = '0;
        xfer         = 1'b0;
        rel          = 1'b0;
        beat_inc     = beat_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    grant_d = N_REQ'(1) << win_idx;
                    ptr_d   = win_idx;
                    beat_d  = '0;
                end
            end
            S_GRANT: begin
                req_ready_o[ptr_q] = !fifo_full_i;
                fifo_data_o        = req_data_i[int'(ptr_q)*DATA_WIDTH +: DATA_WIDTH];
                xfer               = req_valid_i[ptr_q] & !fifo_full_i;
                fifo_write_o       = xfer;
                if (xfer) begin
                    beat_d = beat_inc;
                    rel    = req_last_i[ptr_q] || (beat_inc == BW'(MAX_BURST));
                end
                if (rel) begin
                    beat_d = '0;
                    if (win_found) begin
                        grant_d = N_REQ'(1) << win_idx;
                        ptr_d   = win_idx;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst_n_i) begin
            req_ready_o  = '0;
            fifo_write_o = 1'b0;
            fifo_data_o  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    assign grant_o    = grant_q;
    assign beat_cnt_o = beat_q;

endmodule
